// File: rtl/sd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_pkg : shared state encoding, failure codes and helpers for the    |
// |          SD multi-block read sequencer.                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_WAIT_RUN = 3'd2,
        ST_RUN      = 3'd3,
        ST_CHECK    = 3'd4,
        ST_GAP      = 3'd5
    } sd_state_e;

    localparam logic [1:0] c_err_abort  = 2'b00;
    localparam logic [1:0] c_err_no_run = 2'b01;
    localparam logic [1:0] c_err_crc    = 2'b10;
    localparam logic [1:0] c_err_tmo    = 2'b11;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end
        return v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_read_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_read_seq_if : request and block-reader signals of sd_read_seq.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sd_read_seq_if;
    logic        i_req_vld;
    logic        o_req_rdy;
    logic [15:0] i_req_blocks;
    logic [9:0]  i_req_buf_len;
    logic        i_abort;
    logic        o_rd_start;
    logic [9:0]  o_buf_len;
    logic        i_rd_run;
    logic [3:0]  i_rd_crc_err;
    logic        i_rd_tmo;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic [15:0] o_blk_cnt;

    modport slave (
        input  i_req_vld, i_req_blocks, i_req_buf_len, i_abort,
               i_rd_run, i_rd_crc_err, i_rd_tmo,
        output o_req_rdy, o_rd_start, o_buf_len, o_busy, o_done,
               o_err, o_err_code, o_blk_cnt
    );

    modport master (
        output i_req_vld, i_req_blocks, i_req_buf_len, i_abort,
               i_rd_run, i_rd_crc_err, i_rd_tmo,
        input  o_req_rdy, o_rd_start, o_buf_len, o_busy, o_done,
               o_err, o_err_code, o_blk_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sd_cycle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_cycle_timer : loadable down-counter, expired while count is zero. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sd_cycle_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expired
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/sd_read_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_read_seq : multi-block SD read sequencer with per-block retry.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sd_read_seq
    import sd_pkg::*;
#(
    parameter int MAX_RETRY = 2,
    parameter int RUN_WAIT  = 16,
    parameter int GAP_CYC   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    sd_read_seq_if.slave bus
);

    localparam int TMR_MAX = (RUN_WAIT > GAP_CYC) ? RUN_WAIT : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    // Loads are one less than the span: the expiry cycle is itself counted.
    localparam logic [TMR_W-1:0]   c_run_load  = TMR_W'(RUN_WAIT - 1);
    localparam logic [TMR_W-1:0]   c_gap_load  = TMR_W'(GAP_CYC - 1);
    localparam logic [RETRY_W-1:0] c_max_retry = RETRY_W'(MAX_RETRY);

    sd_state_e          state_q,      state_d;
    logic [15:0]        blocks_q,     blocks_d;
    logic [9:0]         buf_len_q,    buf_len_d;
    logic [15:0]        blk_cnt_q,    blk_cnt_d;
    logic [RETRY_W-1:0] retry_q,      retry_d;
    logic               tmo_sticky_q, tmo_sticky_d;
    logic               no_run_q,     no_run_d;
    logic               done_q,       done_d;
    logic               err_q,        err_d;
    logic [1:0]         err_code_q,   err_code_d;

    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_expired;
    logic               w_attempt_fail;
    logic [15:0]        w_blk_cnt_inc;

    sd_cycle_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expired  (w_tmr_expired)
    );

    assign w_attempt_fail = no_run_q | tmo_sticky_q | (bus.i_rd_crc_err != 4'd0);
    assign w_blk_cnt_inc  = sat_inc16(blk_cnt_q);

    always_comb begin
        state_d      = state_q;
        blocks_d     = blocks_q;
        buf_len_d    = buf_len_q;
        blk_cnt_d    = blk_cnt_q;
        retry_d      = retry_q;
        tmo_sticky_d = tmo_sticky_q;
        no_run_d     = no_run_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req_vld) begin
                    blocks_d   = bus.i_req_blocks;
                    buf_len_d  = bus.i_req_buf_len;
                    blk_cnt_d  = 16'd0;
                    retry_d    = '0;
                    err_code_d = c_err_abort;
                    if (bus.i_req_blocks == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                w_tmr_load   = 1'b1;
                w_tmr_val    = c_run_load;
                tmo_sticky_d = 1'b0;
                no_run_d     = 1'b0;
                state_d      = ST_WAIT_RUN;
            end
            ST_WAIT_RUN: begin
                if (bus.i_rd_run) begin
                    state_d = ST_RUN;
                end else if (w_tmr_expired) begin
                    no_run_d = 1'b1;
                    state_d  = ST_CHECK;
                end
            end
            ST_RUN: begin
                tmo_sticky_d = tmo_sticky_q | bus.i_rd_tmo;
                if (!bus.i_rd_run) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!w_attempt_fail) begin
                    blk_cnt_d = w_blk_cnt_inc;
                    retry_d   = '0;
                    if (w_blk_cnt_inc == blocks_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = c_gap_load;
                        state_d    = ST_GAP;
                    end
                end else if (retry_q < c_max_retry) begin
                    retry_d    = retry_q + RETRY_W'(1);
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_gap_load;
                    state_d    = ST_GAP;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    if (no_run_q) begin
                        err_code_d = c_err_no_run;
                    end else if (tmo_sticky_q) begin
                        err_code_d = c_err_tmo;
                    end else begin
                        err_code_d = c_err_crc;
                    end
                end
            end
            ST_GAP: begin
                if (w_tmr_expired) begin
                    state_d = ST_START;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides whatever the state decided, including a CHECK verdict.
        if ((state_q != ST_IDLE) && bus.i_abort) begin
            state_d    = ST_IDLE;
            blk_cnt_d  = blk_cnt_q;
            retry_d    = retry_q;
            done_d     = 1'b0;
            err_d      = 1'b1;
            err_code_d = c_err_abort;
            w_tmr_load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            blocks_q     <= 16'd0;
            buf_len_q    <= 10'd0;
            blk_cnt_q    <= 16'd0;
            retry_q      <= '0;
            tmo_sticky_q <= 1'b0;
            no_run_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= c_err_abort;
        end else begin
            state_q      <= state_d;
            blocks_q     <= blocks_d;
            buf_len_q    <= buf_len_d;
            blk_cnt_q    <= blk_cnt_d;
            retry_q      <= retry_d;
            tmo_sticky_q <= tmo_sticky_d;
            no_run_q     <= no_run_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign bus.o_req_rdy  = (state_q == ST_IDLE);
    assign bus.o_busy     = (state_q != ST_IDLE);
    assign bus.o_rd_start = (state_q == ST_START);
    assign bus.o_buf_len  = buf_len_q;
    assign bus.o_done     = done_q;
    assign bus.o_err      = err_q;
    assign bus.o_err_code = err_code_q;
    assign bus.o_blk_cnt  = blk_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_read_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sd_read_seq : randomized bench with a transaction-timing model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sd_read_seq;

    localparam int MAX_RETRY = 2;
    localparam int RUN_WAIT  = 16;
    localparam int GAP_CYC   = 8;
    localparam int NCFG      = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    sd_read_seq_if u_if ();

    sd_read_seq #(
        .MAX_RETRY (MAX_RETRY),
        .RUN_WAIT  (RUN_WAIT),
        .GAP_CYC   (GAP_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-attempt reader behaviour: attempt i of the current request uses entry i.
    bit       cfg_nr  [NCFG];
    int       cfg_d   [NCFG];
    int       cfg_l   [NCFG];
    int       cfg_tmo [NCFG];
    logic [3:0] cfg_crc [NCFG];

    // Expected transaction, derived from the request and reader configuration.
    int         exp_starts[$];
    int         obs_starts[$];
    bit         exp_pending = 1'b0;
    int         exp_acc = 0;
    int         exp_end = 0;
    bit         exp_is_done = 1'b0;
    logic [1:0] exp_code = 2'b00;
    int         exp_blk = 0;
    logic [9:0] exp_len = 10'd0;
    int         req_seq = 0;
    bit         rd_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_cfg(input int i, input bit nr, input int d, input int l,
                           input int tmo, input logic [3:0] crc);
        cfg_nr[i] = nr; cfg_d[i] = d; cfg_l[i] = l; cfg_tmo[i] = tmo; cfg_crc[i] = crc;
    endtask

    task automatic gen_cfg(input int i);
        int m;
        m = $urandom_range(0, 9);
        set_cfg(i, ($urandom_range(0, 6) == 0), $urandom_range(0, RUN_WAIT - 1),
                $urandom_range(2, 12), (m == 0) ? 1 : ((m == 1) ? 2 : 0),
                ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
    endtask

    // Timeline: first start one cycle after accept; an attempt's verdict cycle
    // follows from the reader's delay/length; the next start is GAP_CYC later.
    task automatic compute_model(input int n, input int a, input int c);
        int s, k, retry, blk, i;
        bit fail;
        logic [1:0] code;
        exp_starts.delete();
        exp_acc = a; exp_blk = 0; exp_code = 2'b00;
        if (n == 0) begin
            exp_end = a + 1; exp_is_done = 1'b1;
            return;
        end
        s = a + 1; retry = 0; blk = 0; i = 0;
        forever begin
            if (c >= 0 && c < s) begin
                exp_end = c + 1; exp_is_done = 1'b0; exp_code = 2'b00; exp_blk = blk;
                return;
            end
            exp_starts.push_back(s);
            k = cfg_nr[i] ? s + RUN_WAIT + 1 : s + cfg_d[i] + cfg_l[i] + 2;
            if (c >= 0 && c <= k) begin
                exp_end = c + 1; exp_is_done = 1'b0; exp_code = 2'b00; exp_blk = blk;
                return;
            end
            fail = cfg_nr[i] || (cfg_tmo[i] != 0) || (cfg_crc[i] != 4'd0);
            code = cfg_nr[i] ? 2'b01 : ((cfg_tmo[i] != 0) ? 2'b11 : 2'b10);
            if (!fail) begin
                blk++; retry = 0;
                if (blk == n) begin
                    exp_end = k + 1; exp_is_done = 1'b1; exp_blk = blk;
                    return;
                end
            end else if (retry < MAX_RETRY) begin
                retry++;
            end else begin
                exp_end = k + 1; exp_is_done = 1'b0; exp_code = code; exp_blk = blk;
                return;
            end
            s = k + 1 + GAP_CYC;
            i++;
        end
    endtask

    // Block reader: run rises D+1 cycles after start and lasts L cycles.
    initial begin : reader
        int idx, last_seq, c;
        u_if.i_rd_run = 1'b0; u_if.i_rd_tmo = 1'b0; u_if.i_rd_crc_err = 4'd0;
        idx = 0; last_seq = -1;
        forever begin
            @(negedge clk);
            if (rst_n && u_if.o_rd_start) begin
                if (req_seq != last_seq) begin
                    idx = 0; last_seq = req_seq;
                end
                c = idx; idx++;
                rd_busy = 1'b1;
                u_if.i_rd_crc_err = 4'd0;
                if (cfg_nr[c]) begin
                    u_if.i_rd_crc_err = cfg_crc[c];
                end else begin
                    repeat (cfg_d[c] + 1) @(posedge clk);
                    #1;
                    u_if.i_rd_run = 1'b1;
                    u_if.i_rd_tmo = (cfg_tmo[c] == 1);
                    for (int j = 1; j < cfg_l[c]; j++) begin
                        @(posedge clk); #1;
                        u_if.i_rd_tmo = (cfg_tmo[c] == 1) || (cfg_tmo[c] == 2 && j == 1);
                    end
                    @(posedge clk); #1;
                    u_if.i_rd_run = 1'b0;
                    u_if.i_rd_tmo = 1'b0;
                    u_if.i_rd_crc_err = cfg_crc[c];
                end
                rd_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit exp_busy, start_now;
        exp_busy  = exp_pending && (cyc > exp_acc) && (cyc < exp_end);
        start_now = (exp_starts.size() > 0) && (exp_starts[0] == cyc);
        chk("busy", u_if.o_busy, exp_busy);
        chk("req_rdy", u_if.o_req_rdy, !exp_busy);
        chk("done_err_excl", u_if.o_done & u_if.o_err, 1'b0);
        chk("rd_start", u_if.o_rd_start, start_now);
        if (start_now) void'(exp_starts.pop_front());
        if (u_if.o_rd_start) begin
            obs_starts.push_back(cyc);
            chk("buf_len", u_if.o_buf_len, exp_len);
        end
        if (exp_pending && cyc == exp_end) begin
            chk("done", u_if.o_done, exp_is_done);
            chk("err", u_if.o_err, !exp_is_done);
            if (!exp_is_done) chk("err_code", u_if.o_err_code, exp_code);
            chk("blk_cnt", u_if.o_blk_cnt, exp_blk);
        end else begin
            chk("no_done", u_if.o_done, 1'b0);
            chk("no_err", u_if.o_err, 1'b0);
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rdy"},   u_if.o_req_rdy, 1'b1);
        chk({tag, "_busy"},  u_if.o_busy, 1'b0);
        chk({tag, "_start"}, u_if.o_rd_start, 1'b0);
        chk({tag, "_done"},  u_if.o_done, 1'b0);
        chk({tag, "_err"},   u_if.o_err, 1'b0);
        chk({tag, "_code"},  u_if.o_err_code, 2'b00);
        chk({tag, "_blk"},   u_if.o_blk_cnt, 16'd0);
        chk({tag, "_len"},   u_if.o_buf_len, 10'd0);
    endtask

    task automatic wait_reader_idle();
        int g;
        g = 0;
        while (rd_busy && g < 200) begin
            @(posedge clk); g++;
        end
        chk("reader_idle", rd_busy, 1'b0);
    endtask

    task automatic accept(input int n, output int a);
        wait_reader_idle();
        @(posedge clk); #1;
        a = cyc;
        req_seq++;
        obs_starts.delete();
        exp_len = 10'($urandom);
        u_if.i_req_vld = 1'b1;
        u_if.i_req_blocks = 16'(n);
        u_if.i_req_buf_len = exp_len;
        compute_model(n, a, -1);
    endtask

    // ab: -1 no abort, -2 random abort while busy, otherwise cycles after accept.
    task automatic do_req(input int n, input int ab);
        int a, c;
        accept(n, a);
        c = -1;
        if (ab == -2 && exp_end > a + 2) c = a + 1 + $urandom_range(0, exp_end - a - 2);
        else if (ab >= 0) c = a + ab;
        if (c >= 0) compute_model(n, a, c);
        exp_pending = 1'b1;
        @(posedge clk); #1;
        u_if.i_req_vld = 1'b0;
        u_if.i_req_blocks = 16'($urandom);
        u_if.i_req_buf_len = 10'($urandom);
        if (c >= 0) begin
            while (cyc < c) begin @(posedge clk); #1; end
            u_if.i_abort = 1'b1;
            @(posedge clk); #1;
            u_if.i_abort = 1'b0;
        end
        while (cyc <= exp_end) begin @(posedge clk); #1; end
        chk("starts_all_seen", exp_starts.size(), 0);
        exp_pending = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int a;
        logic [1:0] held_code;
        rst_n = 1'b0;
        u_if.i_req_vld = 1'b0; u_if.i_req_blocks = 16'd0;
        u_if.i_req_buf_len = 10'd0; u_if.i_abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Three clean blocks, 20-cycle runs.
        for (int i = 0; i < NCFG; i++) set_cfg(i, 0, 0, 20, 0, 4'd0);
        do_req(3, -1);
        chk("a_model_span", exp_end - exp_acc, 86);
        chk("a_nstarts", obs_starts.size(), 3);
        if (obs_starts.size() == 3) begin
            chk("a_gap01", obs_starts[1] - obs_starts[0], 31);
            chk("a_gap12", obs_starts[2] - obs_starts[1], 31);
        end
        chk("a_blk_final", u_if.o_blk_cnt, 16'd3);

        // CRC on the first two attempts, clean third.
        set_cfg(0, 0, 3, 10, 0, 4'b0010);
        set_cfg(1, 0, 3, 10, 0, 4'b0010);
        set_cfg(2, 0, 3, 10, 0, 4'b0000);
        do_req(1, -1);
        chk("b_nstarts", obs_starts.size(), 3);
        chk("b_model_done", exp_is_done, 1'b1);

        // Reader never runs.
        for (int i = 0; i < NCFG; i++) set_cfg(i, 1, 0, 2, 0, 4'd0);
        do_req(1, -1);
        chk("c_nstarts", obs_starts.size(), 3);
        if (obs_starts.size() == 3) begin
            chk("c_gap01", obs_starts[1] - obs_starts[0], 26);
            chk("c_tail", exp_end - obs_starts[2], 18);
        end
        chk("c_model_code", exp_code, 2'b01);

        // Timeout during every run, some as a single-cycle blip with CRC too.
        for (int i = 0; i < NCFG; i++) set_cfg(i, 0, 1, 6, (i == 1) ? 2 : 1, 4'(i));
        do_req(2, -1);
        chk("d_model_code", exp_code, 2'b11);
        chk("d_model_blk", exp_blk, 0);
        chk("d_code_final", u_if.o_err_code, 2'b11);
        held_code = u_if.o_err_code;

        // Abort while idle is ignored and the error code is held.
        u_if.i_abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        u_if.i_abort = 1'b0;
        chk("idle_abort_code_held", u_if.o_err_code, held_code);
        chk("idle_abort_rdy", u_if.o_req_rdy, 1'b1);

        // Abort during the run of block 2 of 4.
        for (int i = 0; i < NCFG; i++) set_cfg(i, 0, 0, 20, 0, 4'd0);
        do_req(4, 37);
        chk("e_model_blk", exp_blk, 1);
        chk("e_model_span", exp_end - exp_acc, 38);
        chk("e_nstarts", obs_starts.size(), 2);
        repeat (40) @(posedge clk);
        #1;
        chk("e_no_late_start", obs_starts.size(), 2);

        // Reset during GAP, then a zero-block request.
        accept(3, a);
        exp_pending = 1'b1;
        @(posedge clk); #1;
        u_if.i_req_vld = 1'b0;
        while (cyc < a + 27) begin @(posedge clk); #1; end
        chk("f_in_gap_busy", u_if.o_busy, 1'b1);
        exp_pending = 1'b0;
        exp_starts.delete();
        rst_n = 1'b0;
        #1;
        check_reset_vals("f_reset");
        @(posedge clk); #1;
        check_reset_vals("f_reset_held");
        rst_n = 1'b1;
        do_req(0, -1);
        chk("f_model_span", exp_end - exp_acc, 1);
        chk("f_nstarts", obs_starts.size(), 0);

        // Randomized requests with randomized reader behaviour.
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < NCFG; i++) gen_cfg(i);
            do_req($urandom_range(0, 4), ($urandom_range(0, 3) == 0) ? -2 : -1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        wait_reader_idle();
        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
